// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/subtract unit: FSM states and op mode.
package addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_e;
    typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} addsub_mode_e;

endpackage

// File: rtl/digit_addsub_slice.sv
// Combinational DIGIT-bit ripple slice; each bit is a full adder or a full
// subtractor depending on mode, and the carry/borrow ripples bit to bit.
module digit_addsub_slice
    import addsub_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  addsub_mode_e     mode,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        logic fa_s, fa_c, fs_d, fs_b;
        assign fa_s = a[i] ^ b[i] ^ c[i];
        assign fa_c = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        assign fs_d = a[i] ^ b[i] ^ c[i];
        assign fs_b = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
        assign sum[i]   = (mode == MODE_SUB) ? fs_d : fa_s;
        assign c[i + 1] = (mode == MODE_SUB) ? fs_b : fa_c;
    end

    assign cout     = c[DIGIT];
    // Borrow-chain XOR equals carry-chain XOR, so overflow works in both modes.
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-wide ripple slice per cycle, carry held
// in a register between digits, valid/ready on both operand and result sides.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Zero,
    output logic             Overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    addsub_state_e    state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r;
    addsub_mode_e     mode_r;
    logic             carry_r;

    logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
    logic             cout_dig, c_msb;

    assign a_dig = a_r[cnt*DIGIT +: DIGIT];
    assign b_dig = b_r[cnt*DIGIT +: DIGIT];

    digit_addsub_slice #(.DIGIT(DIGIT)) u_slice (
        .a        (a_dig),
        .b        (b_dig),
        .mode     (mode_r),
        .cin      (carry_r),
        .sum      (sum_dig),
        .cout     (cout_dig),
        .c_msb_in (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            mode_r   <= MODE_ADD;
            carry_r  <= 1'b0;
            cnt      <= '0;
            S        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r     <= A;
                    b_r     <= B;
                    mode_r  <= addsub_mode_e'(Sub);
                    carry_r <= 1'b0;
                    cnt     <= '0;
                end
                RUN: begin
                    S[cnt*DIGIT +: DIGIT] <= sum_dig;
                    carry_r <= cout_dig;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        Cout     <= cout_dig;
                        Overflow <= c_msb ^ cout_dig;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero looks only at the registered result, and only while it is presented.
    assign Zero = out_valid && (S == '0);

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench: directed cases on DIGIT=2 plus random sweeps on DIGIT=1/4/8.
module tb_digit_serial_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid[4], in_ready[4], sub_i[4], out_valid[4], out_ready[4];
    logic       cout_o[4], zero_o[4], ovf_o[4];
    logic [7:0] a_i[4], b_i[4], s_o[4];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
        digit_serial_addsub #(.WIDTH(8), .DIGIT(D)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .A(a_i[g]), .B(b_i[g]), .Sub(sub_i[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .S(s_o[g]), .Cout(cout_o[g]), .Zero(zero_o[g]), .Overflow(ovf_o[g])
        );
    end

    function automatic int ndig_of(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer arithmetic, returns {S, Cout, Zero, Overflow}.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [8:0] r;
        logic c, v;
        if (sub) begin
            r = {1'b0, a} - {1'b0, b};
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            c = r[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end
        return {r[7:0], c, (r[7:0] == 8'h00), v};
    endfunction

    // Issues one op on instance k, reports the captured result and the edge count to out_valid.
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input int stall, output logic [10:0] obs, output int lat);
        int guard = 0;
        while (!in_ready[k] && guard < 100) begin @(posedge clk); #1; guard++; end
        in_valid[k] = 1'b1; a_i[k] = a; b_i[k] = b; sub_i[k] = sub;
        @(posedge clk); #1;
        in_valid[k] = 1'b0; a_i[k] = 8'($urandom); b_i[k] = 8'($urandom); sub_i[k] = 1'($urandom);
        lat = 0;
        while (!out_valid[k] && lat < 100) begin @(posedge clk); #1; lat++; end
        obs = {s_o[k], cout_o[k], zero_o[k], ovf_o[k]};
        repeat (stall) @(posedge clk);
        #1;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({in_ready[k], out_valid[k], s_o[k], cout_o[k], zero_o[k], ovf_o[k]} !== 13'b1_0_00000000_0_0_0) begin
                n_fail++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b S=%h C=%b Z=%b V=%b, want rdy=1 vld=0 S=00 C=0 Z=0 V=0",
                         k, in_ready[k], out_valid[k], s_o[k], cout_o[k], zero_o[k], ovf_o[k]);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [5] = '{8'h05, 8'h80, 8'h3C, 8'hFF, 8'h7F};
        logic [7:0]  tb [5] = '{8'h07, 8'h01, 8'h3C, 8'h01, 8'h01};
        logic        ts [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [10:0] te [5] = '{{8'hFE, 3'b100}, {8'h7F, 3'b001}, {8'h00, 3'b010},
                                {8'h00, 3'b110}, {8'h80, 3'b001}};
        logic [10:0] obs;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(0, ta[i], tb[i], ts[i], 0, obs, lat);
            n_checks++;
            if (obs !== te[i] || lat != 4) begin
                n_fail++;
                $display("FAIL directed[%0d]: got {S,C,Z,V}=%h lat=%0d, want %h lat=4", i, obs, lat, te[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        in_valid[0] = 1'b1; a_i[0] = 8'h12; b_i[0] = 8'h34; sub_i[0] = 1'b0;
        @(posedge clk); #1;
        a_i[0] = 8'hAA; b_i[0] = 8'h55;
        while (!out_valid[0] && guard < 50) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid[0], in_ready[0], s_o[0], cout_o[0], zero_o[0], ovf_o[0]} !== {2'b10, 8'h46, 3'b000}) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: vld=%b rdy=%b S=%h C=%b Z=%b V=%b, want vld=1 rdy=0 S=46 flags=000",
                         i, out_valid[0], in_ready[0], s_o[0], cout_o[0], zero_o[0], ovf_o[0]);
            end
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        n_checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL release: vld=%b rdy=%b, want vld=0 rdy=1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [10:0] obs;
        int lat;
        in_valid[0] = 1'b1; a_i[0] = 8'h55; b_i[0] = 8'h22; sub_i[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid[0], in_ready[0], s_o[0]} !== {2'b01, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_run_reset: vld=%b rdy=%b S=%h, want vld=0 rdy=1 S=00", out_valid[0], in_ready[0], s_o[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(0, 8'h10, 8'h01, 1'b1, 0, obs, lat);
        n_checks++;
        if (obs !== {8'h0F, 3'b000} || lat != 4) begin
            n_fail++;
            $display("FAIL after_reset_op: got %h lat=%0d, want %h lat=4", obs, lat, {8'h0F, 3'b000});
        end
    endtask

    task automatic test_sweep();
        logic [10:0] obs, exp_v;
        logic [7:0]  a, b;
        logic        sub;
        int          lat;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 250; i++) begin
                a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                if (i < 4) begin a = (i < 2) ? 8'h00 : 8'hFF; b = (i % 2 == 0) ? 8'h00 : 8'hFF; end
                exp_v = model(a, b, sub);
                run_op(k, a, b, sub, int'($urandom_range(0, 3)), obs, lat);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL sweep[%0d] %h %s %h: got %h, want %h", k, a, sub ? "-" : "+", b, obs, exp_v);
                end
                n_checks++;
                if (lat != ndig_of(k)) begin
                    n_fail++;
                    $display("FAIL latency[%0d]: got %0d, want %0d", k, lat, ndig_of(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, prev, seen;
        logic [10:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            a_i[k] = 8'($urandom); b_i[k] = 8'($urandom); sub_i[k] = 1'($urandom);
            exp_v = model(a_i[k], b_i[k], sub_i[k]);
            in_valid[k] = 1'b1; out_ready[k] = 1'b1;
            cyc = 0; prev = -1; seen = 0;
            repeat (4 * (ndig_of(k) + 2) + 2) begin
                @(posedge clk); #1;
                cyc++;
                if (out_valid[k]) begin
                    n_checks++;
                    if ({s_o[k], cout_o[k], zero_o[k], ovf_o[k]} !== exp_v ||
                        (prev >= 0 && cyc - prev != ndig_of(k) + 2)) begin
                        n_fail++;
                        $display("FAIL throughput[%0d]: got %h gap=%0d, want %h gap=%0d", k,
                                 {s_o[k], cout_o[k], zero_o[k], ovf_o[k]}, cyc - prev, exp_v, ndig_of(k) + 2);
                    end
                    prev = cyc; seen++;
                end
            end
            n_checks++;
            if (seen < 3) begin
                n_fail++;
                $display("FAIL throughput_count[%0d]: got %0d results, want at least 3", k, seen);
            end
            in_valid[k] = 1'b0;
            repeat (ndig_of(k) + 3) @(posedge clk);
            #1;
            out_ready[k] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; sub_i[k] = 1'b0;
            a_i[k] = 8'h00; b_i[k] = 8'h00;
        end
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Multi-cycle, digit-serial unsigned/two's-complement add/subtract unit, parametrised in operand width and digit width. It is the sequential successor to the combinational ripple subtractor. Each cycle it processes DIGIT bits through one ripple slice, with the carry/borrow held in a register between cycles. It uses valid/ready handshakes on both sides, supports a per-operation add/sub mode, and produces carry/borrow, zero and signed-overflow flags. It sits between an operand-issue stage and a result consumer in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, digit cycles per operation.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand valid
in_ready  out  1  unit can accept operands
A  in  WIDTH  minuend / addend
B  in  WIDTH  subtrahend / addend
Sub  in  1  1 = A-B, 0 = A+B; captured with operands
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
S  out  WIDTH  result
Cout  out  1  carry out (add) or borrow out (sub; 1 when A<B unsigned)
Zero  out  1  S == 0
Overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1; out_valid=0.
  - S=0, Cout=0, Zero=0, Overflow=0.
  - Digit counter = 0; carry register = 0; operand registers = 0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch A, B, Sub; carry reg=0; cnt=0; go to RUN.
- State RUN:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each cycle, slice digit cnt: bits [cnt*DIGIT +: DIGIT] with the carry reg as cin.
  - Write the slice sum into S[cnt*DIGIT +: DIGIT]; carry reg <= slice cout; cnt++.
  - On the cycle with cnt==NDIG-1, go to DONE.
  - Also latch Cout = final slice cout, and Overflow = carry into MSB XOR carry out of MSB (the MSB full-cell carry is exported by the slice).
- State DONE:
  - out_valid=1; S, Cout, Zero and Overflow are stable.
  - Zero is computed from the registered S, not the live value.
  - When out_ready=1, go to IDLE. While out_ready=0, hold all outputs (backpressure, no limit).
- Latency: operands accepted at edge t; out_valid rises after edge t+NDIG. Throughput is one result per NDIG+2 cycles with out_ready tied high. There is no accept/emit overlap: in_ready=0 in DONE.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Sub mode: initial borrow-in 0; each bit uses full-subtractor semantics (diff = a^b^bin; bout = (~a&b) | (~(a^b)&bin)).
  - Add mode: full-adder semantics, initial carry-in 0.
- Boundary conditions:
  - DIGIT==WIDTH (NDIG=1): RUN lasts one cycle; the counter width is clamped to a minimum of 1 bit.
  - Counter wraps to 0 on the DONE transition.
  - Operand inputs are ignored outside the IDLE handshake.
  - rst asserted in RUN or DONE: immediate return to IDLE with reset values. The partial result is discarded, with no spurious out_valid.
  - in_valid held high while busy: no acceptance until the next IDLE.

Decomposition:
- Shared package addsub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_e;
  - typedef enum logic {MODE_ADD=0, MODE_SUB=1} addsub_mode_e;
- One sub-module, digit_addsub_slice #(DIGIT): combinational DIGIT-bit ripple of per-bit add/sub cells.
  - Ports: a, b, mode, cin, sum, cout, c_msb_in (carry into the top bit, for overflow).
  - Sub mode reuses the existing full_subtractor cell; add mode uses a full-adder cell. The output is selected by mode.

Test Plan:
- WIDTH=8, DIGIT=2, Sub=1, A=0x05, B=0x07 -> after 4 RUN cycles: S=0xFE, Cout=1, Zero=0, Overflow=0.
- Sub=1, A=0x80, B=0x01 -> S=0x7F, Cout=0, Overflow=1. Sub=1, A=0x3C, B=0x3C -> S=0x00, Zero=1, Cout=0.
- Sub=0, A=0xFF, B=0x01 -> S=0x00, Cout=1, Zero=1, Overflow=0. Sub=0, A=0x7F, B=0x01 -> S=0x80, Overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, S and flags stable, in_ready=0. Then release -> one transfer, IDLE next cycle.
- Assert rst mid-RUN (cnt=2) -> out_valid=0 and in_ready=1 immediately. A new op A=0x10, B=0x01 (sub) afterwards -> S=0x0F.
- Sweep DIGIT in {1, 4, 8} against a reference model over 1000 random ops with random out_ready. Check latency NDIG, throughput, and that results match A±B mod 2^8 with correct flags.
